alu_exec_unit: RTL

//   Multi-cycle execute unit consuming the 4-bit ALU operation code that the ALU control decoder produces.

---
 rtl/alu_exec_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, bit-serial shifts, valid/ready on both sides.
// Results are registered and held in DONE until downstream accepts them.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         aluop_in,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 illegal_q, illegal_d;

    logic                 load;
    logic [WIDTH-1:0]     res_val;
    logic [SHAMT_W-1:0]   shamt;

    function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] val);
        case (op)
            OP_SLL:  shift1 = {val[WIDTH-2:0], 1'b0};
            OP_SRL:  shift1 = {1'b0, val[WIDTH-1:1]};
            default: shift1 = {val[WIDTH-1], val[WIDTH-1:1]};
        endcase
    endfunction

    assign in_ready  = rst_n & (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign shamt     = op_b[SHAMT_W-1:0];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        load      = 1'b0;
        res_val   = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d      = aluop_in;
                    illegal_d = 1'b0;
                    state_d   = S_DONE;
                    load      = 1'b1;
                    case (aluop_in)
                        OP_AND: res_val = op_a & op_b;
                        OP_OR:  res_val = op_a | op_b;
                        OP_ADD: res_val = op_a + op_b;
                        OP_SUB: res_val = op_a - op_b;
                        OP_SLT: res_val = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                        OP_NOR: res_val = ~(op_a | op_b);
                        OP_SLL, OP_SRL, OP_SRA: begin
                            // First shift happens on the accept edge so latency equals shamt.
                            if (shamt == '0) begin
                                res_val = op_a;
                            end else if (shamt == SHAMT_W'(1)) begin
                                res_val = shift1(aluop_in, op_a);
                            end else begin
                                load    = 1'b0;
                                work_d  = shift1(aluop_in, op_a);
                                cnt_d   = shamt - SHAMT_W'(1);
                                state_d = S_SHIFT;
                            end
                        end
                        default: begin
                            res_val   = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                if (cnt_q == SHAMT_W'(1)) begin
                    load    = 1'b1;
                    res_val = shift1(op_q, work_q);
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    work_d = shift1(op_q, work_q);
                    cnt_d  = cnt_q - SHAMT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        result_d = load ? res_val : result_q;
        zero_d   = load ? (res_val == '0) : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

endmodule
